// File: rtl/dff_re_checker_pkg.sv
// Shared types, default widths and helpers for the dff_re streaming checker.
package dff_check_pkg;

  typedef enum logic [1:0] {
    WAIT_RST = 2'd0,
    RUN      = 2'd1,
    DONE     = 2'd2
  } state_t;

  localparam int unsigned TS_W  = 32;
  localparam int unsigned CNT_W = 16;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dff_re_checker_model.sv
// Cycle-exact reference model of dff_re driven from the sampled vector stream.
module dff_re_model
  import dff_check_pkg::*;
#(
  parameter bit MODEL_ASYNC_RST = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic accept,
  input  logic s_clk,
  input  logic s_rst_n,
  input  logic s_enable,
  input  logic s_d,
  output logic exp_q_next,
  output logic known_next
);

  logic prev_clk;
  logic exp_q;
  logic known;
  logic rise;

  assign rise = s_clk && !prev_clk;

  // Model state after applying the current sample; known only becomes set by a reset.
  always_comb begin
    exp_q_next = exp_q;
    known_next = known;
    if (MODEL_ASYNC_RST && !s_rst_n) begin
      exp_q_next = 1'b0;
      known_next = 1'b1;
    end else if (rise) begin
      if (!s_rst_n) begin
        exp_q_next = 1'b0;
        known_next = 1'b1;
      end else if (s_enable) begin
        exp_q_next = s_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      prev_clk <= 1'b0;
      exp_q    <= 1'b0;
      known    <= 1'b0;
    end else if (accept) begin
      prev_clk <= s_clk;
      exp_q    <= exp_q_next;
      known    <= known_next;
    end
  end

endmodule

// File: rtl/dff_re_checker.sv
// Streaming self-check of dff_re samples: reference model, mismatch counting and status capture.
module dff_re_checker
  import dff_check_pkg::*;
#(
  parameter int unsigned TS_W            = dff_check_pkg::TS_W,
  parameter int unsigned CNT_W           = dff_check_pkg::CNT_W,
  parameter bit          MODEL_ASYNC_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [TS_W-1:0]   s_timestamp,
  input  logic              s_clk,
  input  logic              s_rst_n,
  input  logic              s_enable,
  input  logic              s_d,
  input  logic              s_q,
  input  logic              s_last,
  output logic              err_pulse,
  output logic [TS_W-1:0]   err_ts,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  sample_count,
  output logic              first_err_valid,
  output logic [TS_W-1:0]   first_err_ts,
  output logic              fail,
  output logic              done
);

  state_t state;
  logic   accept;
  logic   compare;
  logic   mismatch;
  logic   exp_q_next;
  logic   known_next;

  // clear wins over a coincident sample, which is then not consumed.
  assign accept   = s_valid && s_ready && !clear;
  assign compare  = accept && known_next;
  assign mismatch = compare && (s_q != exp_q_next);

  dff_re_model #(
    .MODEL_ASYNC_RST(MODEL_ASYNC_RST)
  ) u_model (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .accept     (accept),
    .s_clk      (s_clk),
    .s_rst_n    (s_rst_n),
    .s_enable   (s_enable),
    .s_d        (s_d),
    .exp_q_next (exp_q_next),
    .known_next (known_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state           <= WAIT_RST;
      s_ready         <= 1'b1;
      err_pulse       <= 1'b0;
      err_ts          <= '0;
      err_count       <= '0;
      sample_count    <= '0;
      first_err_valid <= 1'b0;
      first_err_ts    <= '0;
      fail            <= 1'b0;
      done            <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (compare) begin
        sample_count <= CNT_W'(sat_inc(32'(sample_count), CNT_W));
      end
      if (mismatch) begin
        err_count <= CNT_W'(sat_inc(32'(err_count), CNT_W));
        err_pulse <= 1'b1;
        err_ts    <= s_timestamp;
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_ts    <= s_timestamp;
          fail            <= 1'b1;
        end
      end
      // The last sample is fully processed before the session closes.
      if (accept) begin
        if (s_last) begin
          state   <= DONE;
          s_ready <= 1'b0;
          done    <= 1'b1;
        end else if (state == WAIT_RST && known_next) begin
          state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_dff_re_checker.sv
// Directed table-driven bench for dff_re_checker (default, 4-bit counter and sync-reset-model builds).
module tb_dff_re_checker;
  import dff_check_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, clear, s_valid;
  logic [31:0] s_timestamp;
  logic        s_clk, s_rst_n, s_enable, s_d, s_q, s_last;

  logic        a_ready, a_pulse, a_fev, a_fail, a_done;
  logic [31:0] a_ets, a_fts;
  logic [15:0] a_ecnt, a_scnt;
  logic        b_ready, b_pulse, b_fev, b_fail, b_done;
  logic [31:0] b_ets, b_fts;
  logic [3:0]  b_ecnt, b_scnt;
  logic        c_ready, c_pulse, c_fev, c_fail, c_done;
  logic [31:0] c_ets, c_fts;
  logic [15:0] c_ecnt, c_scnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dff_re_checker dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid), .s_ready(a_ready),
    .s_timestamp(s_timestamp), .s_clk(s_clk), .s_rst_n(s_rst_n), .s_enable(s_enable),
    .s_d(s_d), .s_q(s_q), .s_last(s_last), .err_pulse(a_pulse), .err_ts(a_ets),
    .err_count(a_ecnt), .sample_count(a_scnt), .first_err_valid(a_fev),
    .first_err_ts(a_fts), .fail(a_fail), .done(a_done)
  );

  dff_re_checker #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid), .s_ready(b_ready),
    .s_timestamp(s_timestamp), .s_clk(s_clk), .s_rst_n(s_rst_n), .s_enable(s_enable),
    .s_d(s_d), .s_q(s_q), .s_last(s_last), .err_pulse(b_pulse), .err_ts(b_ets),
    .err_count(b_ecnt), .sample_count(b_scnt), .first_err_valid(b_fev),
    .first_err_ts(b_fts), .fail(b_fail), .done(b_done)
  );

  dff_re_checker #(.MODEL_ASYNC_RST(1'b0)) dut_sync (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid), .s_ready(c_ready),
    .s_timestamp(s_timestamp), .s_clk(s_clk), .s_rst_n(s_rst_n), .s_enable(s_enable),
    .s_d(s_d), .s_q(s_q), .s_last(s_last), .err_pulse(c_pulse), .err_ts(c_ets),
    .err_count(c_ecnt), .sample_count(c_scnt), .first_err_valid(c_fev),
    .first_err_ts(c_fts), .fail(c_fail), .done(c_done)
  );

  typedef struct {
    int          grp;
    logic [31:0] ts;
    logic        c, r, e, d, q, l;
    logic        pulse;
    int          ecnt, scnt;
    logic [31:0] ets;
    logic        fev, dn;
    logic        cs, sp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int grp, input int ts, input logic c, input logic r,
                              input logic e, input logic d, input logic q, input logic l,
                              input logic pulse, input int ecnt, input int scnt, input int ets,
                              input logic fev, input logic dn, input logic cs, input logic sp);
    vec_t v;
    v.grp = grp; v.ts = 32'(ts); v.c = c; v.r = r; v.e = e; v.d = d; v.q = q; v.l = l;
    v.pulse = pulse; v.ecnt = ecnt; v.scnt = scnt; v.ets = 32'(ets);
    v.fev = fev; v.dn = dn; v.cs = cs; v.sp = sp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input int ts, input logic c, input logic r, input logic e,
                       input logic d, input logic q, input logic l);
    s_valid = 1'b1; s_timestamp = 32'(ts);
    s_clk = c; s_rst_n = r; s_enable = e; s_d = d; s_q = q; s_last = l;
  endtask

  task automatic idle();
    s_valid = 1'b0; s_last = 1'b0; clear = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, 32'(a_ready), 32'd1);
    chk({tag, "_pulse"}, 32'(a_pulse), 32'd0);
    chk({tag, "_err_ts"}, a_ets, 32'd0);
    chk({tag, "_err_count"}, 32'(a_ecnt), 32'd0);
    chk({tag, "_sample_count"}, 32'(a_scnt), 32'd0);
    chk({tag, "_first_valid"}, 32'(a_fev), 32'd0);
    chk({tag, "_first_ts"}, a_fts, 32'd0);
    chk({tag, "_fail"}, 32'(a_fail), 32'd0);
    chk({tag, "_done"}, 32'(a_done), 32'd0);
    chk({tag, "_sat_count"}, 32'(b_ecnt), 32'd0);
  endtask

  task automatic run_group(input int g);
    foreach (vq[i]) begin
      if (vq[i].grp == g) begin
        drive(int'(vq[i].ts), vq[i].c, vq[i].r, vq[i].e, vq[i].d, vq[i].q, vq[i].l);
        step();
        chk($sformatf("g%0d_ts%0d_pulse", g, vq[i].ts), 32'(a_pulse), 32'(vq[i].pulse));
        chk($sformatf("g%0d_ts%0d_err_count", g, vq[i].ts), 32'(a_ecnt), 32'(vq[i].ecnt));
        chk($sformatf("g%0d_ts%0d_sample_count", g, vq[i].ts), 32'(a_scnt), 32'(vq[i].scnt));
        chk($sformatf("g%0d_ts%0d_err_ts", g, vq[i].ts), a_ets, vq[i].ets);
        chk($sformatf("g%0d_ts%0d_fail", g, vq[i].ts), 32'(a_fail), 32'(vq[i].fev));
        chk($sformatf("g%0d_ts%0d_done", g, vq[i].ts), 32'(a_done), 32'(vq[i].dn));
        chk($sformatf("g%0d_ts%0d_ready", g, vq[i].ts), 32'(a_ready), 32'(!vq[i].dn));
        if (vq[i].cs)
          chk($sformatf("g%0d_ts%0d_sync_pulse", g, vq[i].ts), 32'(c_pulse), 32'(vq[i].sp));
      end
    end
    idle();
  endtask

  initial begin
    // group 1: pre-reset vectors, reset vector, clean clocked stream, sample after done
    vq.push_back(mk(1,  0, 0,1,0,0,1,0, 0,0,0, 0,0,0, 0,0));
    vq.push_back(mk(1,  1, 1,1,1,1,0,0, 0,0,0, 0,0,0, 0,0));
    vq.push_back(mk(1,  2, 0,1,0,0,1,0, 0,0,0, 0,0,0, 0,0));
    vq.push_back(mk(1,  3, 1,1,1,0,1,0, 0,0,0, 0,0,0, 0,0));
    vq.push_back(mk(1,  4, 0,0,0,0,0,0, 0,0,1, 0,0,0, 0,0));
    vq.push_back(mk(1,  5, 1,1,1,1,1,0, 0,0,2, 0,0,0, 0,0));
    vq.push_back(mk(1,  6, 0,1,1,0,1,0, 0,0,3, 0,0,0, 0,0));
    vq.push_back(mk(1,  7, 1,1,1,0,0,0, 0,0,4, 0,0,0, 0,0));
    vq.push_back(mk(1,  8, 0,1,0,1,0,0, 0,0,5, 0,0,0, 0,0));
    vq.push_back(mk(1,  9, 1,1,0,1,0,0, 0,0,6, 0,0,0, 0,0));
    vq.push_back(mk(1, 10, 0,1,1,1,0,0, 0,0,7, 0,0,0, 0,0));
    vq.push_back(mk(1, 11, 1,1,1,1,1,0, 0,0,8, 0,0,0, 0,0));
    vq.push_back(mk(1, 12, 0,1,0,0,1,1, 0,0,9, 0,0,1, 0,0));
    vq.push_back(mk(1, 13, 1,1,1,0,1,0, 0,0,9, 0,0,1, 0,0));
    // group 2: single fault at 40, hold across disabled edges, then q follows d
    vq.push_back(mk(2, 20, 0,0,0,0,0,0, 0,0,1,  0,0,0, 0,0));
    vq.push_back(mk(2, 30, 0,1,1,1,0,0, 0,0,2,  0,0,0, 0,0));
    vq.push_back(mk(2, 40, 1,1,1,1,0,0, 1,1,3, 40,1,0, 0,0));
    vq.push_back(mk(2, 41, 0,1,1,1,1,0, 0,1,4, 40,1,0, 0,0));
    vq.push_back(mk(2, 50, 1,1,0,0,1,0, 0,1,5, 40,1,0, 0,0));
    vq.push_back(mk(2, 51, 0,1,0,1,1,0, 0,1,6, 40,1,0, 0,0));
    vq.push_back(mk(2, 52, 1,1,0,1,1,0, 0,1,7, 40,1,0, 0,0));
    vq.push_back(mk(2, 53, 0,1,0,0,1,0, 0,1,8, 40,1,0, 0,0));
    vq.push_back(mk(2, 54, 1,1,0,0,1,0, 0,1,9, 40,1,0, 0,0));
    vq.push_back(mk(2, 55, 0,1,0,0,1,0, 0,1,10,40,1,0, 0,0));
    vq.push_back(mk(2, 60, 1,1,0,0,0,0, 1,2,11,60,1,0, 0,0));
    vq.push_back(mk(2, 61, 0,1,0,1,1,0, 0,2,12,60,1,0, 0,0));
    vq.push_back(mk(2, 62, 1,1,0,0,0,0, 1,3,13,62,1,0, 0,0));
    vq.push_back(mk(2, 63, 0,1,0,1,1,0, 0,3,14,62,1,0, 0,0));
    vq.push_back(mk(2, 64, 1,1,0,0,0,0, 1,4,15,64,1,0, 0,0));
    vq.push_back(mk(2, 65, 0,1,0,0,0,0, 1,5,16,65,1,0, 0,0));
    vq.push_back(mk(2, 66, 0,1,0,0,1,1, 0,5,17,65,1,1, 0,0));
    // group 3: reset with s_clk low, async vs sync-on-edge model
    vq.push_back(mk(3, 100, 1,0,0,0,0,0, 0,0,1,   0,0,0, 1,0));
    vq.push_back(mk(3, 101, 0,1,1,1,0,0, 0,0,2,   0,0,0, 1,0));
    vq.push_back(mk(3, 102, 1,1,1,1,1,0, 0,0,3,   0,0,0, 1,0));
    vq.push_back(mk(3, 103, 0,0,0,0,1,0, 1,1,4, 103,1,0, 1,0));
    vq.push_back(mk(3, 104, 1,0,0,0,1,0, 1,2,5, 104,1,0, 1,1));

    rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_timestamp = '0;
    s_clk = 1'b0; s_rst_n = 1'b1; s_enable = 1'b0; s_d = 1'b0; s_q = 1'b0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_idle("reset");

    run_group(1);

    // clear with a coincident mismatching sample: sample dropped, state back to reset
    drive(14, 0, 0, 0, 0, 1, 0);
    clear = 1'b1;
    step();
    idle();
    check_idle("clear_with_valid");

    run_group(2);
    chk("first_err_ts", a_fts, 32'd40);
    chk("first_err_valid", 32'(a_fev), 32'd1);

    clear = 1'b1;
    step();
    idle();
    check_idle("clear_after_g2");

    run_group(3);
    chk("sync_err_count", 32'(c_ecnt), 32'd1);
    chk("sync_first_ts", c_fts, 32'd104);

    clear = 1'b1;
    step();
    idle();

    // saturation: one reset vector then 20 back-to-back mismatches
    drive(200, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 20; i++) begin
      drive(201 + i, 0, 0, 0, 0, 1, 0);
      step();
      if (i == 9) chk("sat_pulse_run", 32'(b_pulse), 32'd1);
    end
    chk("sat_err_count", 32'(b_ecnt), 32'd15);
    chk("sat_sample_count", 32'(b_scnt), 32'd15);
    chk("wide_err_count", 32'(a_ecnt), 32'd20);
    chk("wide_sample_count", 32'(a_scnt), 32'd21);
    chk("wide_err_ts", a_ets, 32'd220);
    chk("wide_first_ts", a_fts, 32'd201);

    // rst_n low mid-stream with a sample in flight
    drive(221, 0, 0, 0, 0, 1, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle();
    check_idle("rst_midstream");
    chk("rst_sat_sample_count", 32'(b_scnt), 32'd0);

    step();
    chk("post_rst_ready", 32'(a_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dff_re_checker.md
# dff_re_checker

Streaming self-check stage that sits directly downstream of the `dff_re` split-simulation DUT stage. It consumes the per-vector sample stream (timestamp, applied inputs, observed `q`), runs a cycle-exact reference model of `dff_re`, and compares the observed `q` against the modelled `q`. It produces:
- a saturating mismatch count;
- a first-failure timestamp;
- pass/fail/done status.

This replaces offline CSV diffing.

## Interface
Parameters:
- `TS_W`, 32: width of the sample timestamp.
- `CNT_W`, 16: width of the sample and mismatch counters.
- `MODEL_ASYNC_RST`, 1:
  - 1: the model treats `rst_n` low as forcing `q` = 0 on any sample.
  - 0: reset takes effect only on a rising `clk` sample.

Ports:
- `clk`, in, 1: checker clock.
- `rst_n`, in, 1: reset; synchronous, active-low.
- `clear`, in, 1: synchronous restart of the check session.
- `s_valid`, in, 1: sample valid.
- `s_ready`, out, 1: checker accepts the sample.
- `s_timestamp`, in, `TS_W`: vector timestamp.
- `s_clk`, `s_rst_n`, `s_enable`, `s_d`, in, 1 each: inputs applied to the DUT for this vector.
- `s_q`, in, 1: DUT `q` observed after propagation.
- `s_last`, in, 1: final vector of the stream.
- `err_pulse`, out, 1: one-cycle pulse per mismatching sample.
- `err_ts`, out, `TS_W`: timestamp of the most recent mismatch.
- `err_count`, out, `CNT_W`: saturating mismatch count.
- `sample_count`, out, `CNT_W`: saturating count of compared samples.
- `first_err_valid`, out, 1: a mismatch has been recorded.
- `first_err_ts`, out, `TS_W`: timestamp of the first mismatch.
- `fail`, out, 1: sticky; equals `first_err_valid`.
- `done`, out, 1: `s_last` has been accepted.

## Operation
- Accept condition: `s_valid && s_ready`. `s_ready` = (state != DONE). No other backpressure.
- Edge detect:
  - `prev_clk` holds `s_clk` of the last accepted sample; it is reset and cleared to 0.
  - A rising edge is `s_clk` = 1 with `prev_clk` = 0.
  - The first sample with `s_clk` = 1 after reset counts as a rising edge.
- Model update per accepted sample:
  - With `MODEL_ASYNC_RST` = 1 and `s_rst_n` = 0: `exp_q` = 0.
  - Otherwise, on a rising edge:
    - `s_rst_n` = 0: `exp_q` = 0.
    - `s_enable` = 1: `exp_q` = `s_d`.
    - else: `exp_q` holds.
  - The comparison uses the updated `exp_q` against the same sample's `s_q`.
- States:
  - **WAIT_RST**: `exp_q` is unknown, so no comparisons are made.
    - Moves to RUN on an accepted sample that sets `exp_q` to 0 via reset (rule above). That sample is compared.
  - **RUN**: every accepted sample is compared. `sample_count` increments.
    - On a mismatch:
      - `err_count` increments;
      - `err_pulse` fires and `err_ts` loads the timestamp;
      - if `first_err_valid` = 0, then `first_err_ts` loads and `first_err_valid` is set.
  - **DONE**: entered from WAIT_RST or RUN when an accepted sample has `s_last` = 1. That sample is still processed first. `s_ready` = 0.
    - Leaves only via `clear` or `rst_n`.
- Counters saturate at all-ones and never wrap.
- `clear` has priority over a simultaneous sample; that sample is not accepted. `clear` returns the block to its post-reset state.
- `rst_n` low mid-stream aborts the session and drops the in-flight sample.

## Timing
- All outputs are registered. Status for sample N is visible the cycle after it is accepted.
- Throughput: one sample per cycle.
- Reset values:
  - state = WAIT_RST, so `s_ready` = 1 in the first cycle after reset;
  - `err_pulse` = 0, `err_ts` = 0, `err_count` = 0, `sample_count` = 0;
  - `first_err_valid` = 0, `first_err_ts` = 0, `fail` = 0, `done` = 0;
  - `exp_q` = 0, `prev_clk` = 0.
- `err_pulse` is high for exactly one cycle per mismatching sample. Back-to-back mismatches keep it high on consecutive cycles.

## Structure
- Package `dff_check_pkg` holds:
  - the state enum (WAIT_RST, RUN, DONE);
  - default width constants `TS_W` and `CNT_W`;
  - the saturating-increment function.
- Sub-module `dff_re_model`: contains `prev_clk`, `exp_q` and `known`. Inputs: sample bits and an accept strobe. Outputs: `exp_q_next` and `known_next`. It is reused by future `dff_re` variants.
- The top level holds the FSM, counters and capture registers.

## Test plan
- Clean stream: reset vector (0,0,0,0, q = 0), then 8 enable/d toggling clock vectors, all `q` matching the model, last vector with `s_last` → `err_count` = 0, `fail` = 0, `done` = 1, `s_ready` = 0.
- Single fault: at timestamp 40 on a rising edge with `enable` = 1, `d` = 1, drive `q` = 0 → `err_pulse` for one cycle, `first_err_ts` = 40, `err_count` = 1. A later mismatch at ts 60 leaves `first_err_ts` = 40 and sets `err_ts` = 60.
- Hold behaviour: `enable` = 0 with `d` toggling across 3 rising edges and `q` held → no mismatch. Driving `q` = `d` instead → 3 mismatches.
- Pre-reset vectors: 4 vectors with `rst_n` = 1 and arbitrary `q` before the first reset vector → `sample_count` = 0, no errors. After the reset vector, counting starts.
- `MODEL_ASYNC_RST` = 0: a `rst_n` = 0 sample with `s_clk` = 0 and `q` = 1 → no mismatch. The next rising-edge sample with `q` = 1 → mismatch.
- Saturation and control:
  - with `CNT_W` = 4, 20 mismatches → `err_count` = 15;
  - `clear` asserted together with `s_valid` → sample ignored, all outputs return to reset values;
  - `rst_n` low mid-stream → same outcome.
